// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - shares the 4-digit display between primary digits and timed messages
module display_arbiter #(
    parameter int HOLD_MS  = 2000,
    parameter int GAP_MS   = 100,
    parameter int BLINK_MS = 250
) (
    input  logic       clk1KHz,
    input  logic       rst,
    input  logic [3:0] p_digit1,
    input  logic [3:0] p_digit2,
    input  logic [3:0] p_digit3,
    input  logic [3:0] p_digit4,
    input  logic [3:0] blink_mask,
    input  logic       msg_req,
    input  logic [3:0] m_digit1,
    input  logic [3:0] m_digit2,
    input  logic [3:0] m_digit3,
    input  logic [3:0] m_digit4,
    output logic       msg_ack,
    output logic       busy,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic [3:0] blank
);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

    localparam logic [15:0] HOLD_LD    = 16'(HOLD_MS - 1);
    localparam logic [15:0] GAP_LD     = 16'(GAP_MS - 1);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_MS - 1);

    state_t      r_state, w_state_nx;
    logic [15:0] r_cnt, w_cnt_nx;
    logic [15:0] r_bcnt;
    logic        r_phase;
    logic [3:0]  r_m1, r_m2, r_m3, r_m4;
    logic [3:0]  w_m1_nx, w_m2_nx, w_m3_nx, w_m4_nx;
    logic [3:0]  r_digit1, r_digit2, r_digit3, r_digit4;
    logic [3:0]  w_digit1_nx, w_digit2_nx, w_digit3_nx, w_digit4_nx;
    logic [3:0]  r_blank, w_blank_nx;
    logic        r_ack, w_ack_nx;
    logic        r_busy, w_busy_nx;
    logic [3:0]  w_idle_blank;

    // Blinking digits are hidden while phase is 0
    assign w_idle_blank = blink_mask & {4{~r_phase}};

    // Free-running blink phase generator, independent of the arbiter state
    always_ff @(posedge clk1KHz or posedge rst) begin
        if (rst) begin
            r_bcnt  <= 16'd0;
            r_phase <= 1'b1;
        end else if (r_bcnt == BLINK_LAST) begin
            r_bcnt  <= 16'd0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt  <= r_bcnt + 16'd1;
        end
    end

    // Next state and next registered outputs; outputs follow the state being entered
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_m1_nx     = r_m1;
        w_m2_nx     = r_m2;
        w_m3_nx     = r_m3;
        w_m4_nx     = r_m4;
        w_digit1_nx = r_digit1;
        w_digit2_nx = r_digit2;
        w_digit3_nx = r_digit3;
        w_digit4_nx = r_digit4;
        w_blank_nx  = r_blank;
        w_ack_nx    = 1'b0;
        w_busy_nx   = r_busy;
        case (r_state)
            S_IDLE: begin
                w_digit1_nx = p_digit1;
                w_digit2_nx = p_digit2;
                w_digit3_nx = p_digit3;
                w_digit4_nx = p_digit4;
                w_blank_nx  = w_idle_blank;
                w_busy_nx   = 1'b0;
                if (msg_req) begin
                    w_m1_nx     = m_digit1;
                    w_m2_nx     = m_digit2;
                    w_m3_nx     = m_digit3;
                    w_m4_nx     = m_digit4;
                    w_digit1_nx = m_digit1;
                    w_digit2_nx = m_digit2;
                    w_digit3_nx = m_digit3;
                    w_digit4_nx = m_digit4;
                    w_blank_nx  = 4'b0000;
                    w_ack_nx    = 1'b1;
                    w_busy_nx   = 1'b1;
                    w_cnt_nx    = HOLD_LD;
                    w_state_nx  = S_SHOW;
                end
            end
            S_SHOW: begin
                w_digit1_nx = r_m1;
                w_digit2_nx = r_m2;
                w_digit3_nx = r_m3;
                w_digit4_nx = r_m4;
                w_blank_nx  = 4'b0000;
                w_busy_nx   = 1'b1;
                if (r_cnt != 16'd0) begin
                    w_cnt_nx = r_cnt - 16'd1;
                end else if (GAP_MS > 0) begin
                    w_cnt_nx   = GAP_LD;
                    w_blank_nx = 4'b1111;
                    w_state_nx = S_GAP;
                end else begin
                    w_digit1_nx = p_digit1;
                    w_digit2_nx = p_digit2;
                    w_digit3_nx = p_digit3;
                    w_digit4_nx = p_digit4;
                    w_blank_nx  = w_idle_blank;
                    w_busy_nx   = 1'b0;
                    w_state_nx  = S_IDLE;
                end
            end
            S_GAP: begin
                w_blank_nx = 4'b1111;
                w_busy_nx  = 1'b1;
                if (r_cnt != 16'd0) begin
                    w_cnt_nx = r_cnt - 16'd1;
                end else begin
                    w_digit1_nx = p_digit1;
                    w_digit2_nx = p_digit2;
                    w_digit3_nx = p_digit3;
                    w_digit4_nx = p_digit4;
                    w_blank_nx  = w_idle_blank;
                    w_busy_nx   = 1'b0;
                    w_state_nx  = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State, counter, message latch and output registers; reset aborts any message
    always_ff @(posedge clk1KHz or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 16'd0;
            r_m1     <= 4'h0;
            r_m2     <= 4'h0;
            r_m3     <= 4'h0;
            r_m4     <= 4'h0;
            r_digit1 <= 4'h0;
            r_digit2 <= 4'h0;
            r_digit3 <= 4'h0;
            r_digit4 <= 4'h0;
            r_blank  <= 4'b0000;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_m1     <= w_m1_nx;
            r_m2     <= w_m2_nx;
            r_m3     <= w_m3_nx;
            r_m4     <= w_m4_nx;
            r_digit1 <= w_digit1_nx;
            r_digit2 <= w_digit2_nx;
            r_digit3 <= w_digit3_nx;
            r_digit4 <= w_digit4_nx;
            r_blank  <= w_blank_nx;
            r_ack    <= w_ack_nx;
            r_busy   <= w_busy_nx;
        end
    end

    assign msg_ack = r_ack;
    assign busy    = r_busy;
    assign digit1  = r_digit1;
    assign digit2  = r_digit2;
    assign digit3  = r_digit3;
    assign digit4  = r_digit4;
    assign blank   = r_blank;

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - randomized self-checking bench for display_arbiter
module tb_display_arbiter;

    localparam int H = 4;
    localparam int G = 2;
    localparam int B = 3;

    logic       clk;
    logic       rst;
    logic [3:0] p_digit1, p_digit2, p_digit3, p_digit4;
    logic [3:0] blink_mask;
    logic       msg_req;
    logic [3:0] m_digit1, m_digit2, m_digit3, m_digit4;
    logic       msg_ack, busy;
    logic [3:0] digit1, digit2, digit3, digit4;
    logic [3:0] blank;

    int total = 0;
    int bad   = 0;

    // Reference model state: edge index since reset release, grant edge, latched message
    int          k;
    bit          active;
    int          g;
    logic [15:0] md;
    logic [21:0] e_obs;

    display_arbiter #(.HOLD_MS(H), .GAP_MS(G), .BLINK_MS(B)) dut (
        .clk1KHz   (clk),
        .rst       (rst),
        .p_digit1  (p_digit1),
        .p_digit2  (p_digit2),
        .p_digit3  (p_digit3),
        .p_digit4  (p_digit4),
        .blink_mask(blink_mask),
        .msg_req   (msg_req),
        .m_digit1  (m_digit1),
        .m_digit2  (m_digit2),
        .m_digit3  (m_digit3),
        .m_digit4  (m_digit4),
        .msg_ack   (msg_ack),
        .busy      (busy),
        .digit1    (digit1),
        .digit2    (digit2),
        .digit3    (digit3),
        .digit4    (digit4),
        .blank     (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] obs();
        return {msg_ack, busy, digit1, digit2, digit3, digit4, blank};
    endfunction

    function automatic void model_reset();
        k      = 0;
        active = 1'b0;
        g      = 0;
        md     = 16'h0;
        e_obs  = 22'h0;
    endfunction

    // Expected outputs after edge k, from the timing rules: show for H edges, gap for G, then idle
    function automatic void model_edge();
        bit          free;
        logic [3:0]  bl;
        logic [15:0] pd;
        free = !active || (k > g + H + G);
        bl   = ((k / B) % 2 == 1) ? blink_mask : 4'b0000;
        pd   = {p_digit1, p_digit2, p_digit3, p_digit4};
        if (free && msg_req) begin
            active = 1'b1;
            g      = k;
            md     = {m_digit1, m_digit2, m_digit3, m_digit4};
            e_obs  = {1'b1, 1'b1, md, 4'b0000};
        end else if (free || k == g + H + G) begin
            e_obs = {1'b0, 1'b0, pd, bl};
        end else if (k - g < H) begin
            e_obs = {1'b0, 1'b1, md, 4'b0000};
        end else begin
            e_obs = {1'b0, 1'b1, md, 4'b1111};
        end
        k = k + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic rand_primary();
        p_digit1 = 4'($urandom_range(0, 15));
        p_digit2 = 4'($urandom_range(0, 15));
        p_digit3 = 4'($urandom_range(0, 15));
        p_digit4 = 4'($urandom_range(0, 15));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        p_digit1 = 4'h7; p_digit2 = 4'h7; p_digit3 = 4'h7; p_digit4 = 4'h7;
        blink_mask = 4'b0000;
        msg_req = 1'b0;
        m_digit1 = 4'h0; m_digit2 = 4'h0; m_digit3 = 4'h0; m_digit4 = 4'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        total++;
        if (obs() !== e_obs) begin
            bad++;
            $display("FAIL reset_hold got=%h exp=%h", obs(), e_obs);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_primary();
            step();
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (obs() !== e_obs) begin
            bad++;
            $display("FAIL reset_async got=%h exp=%h", obs(), e_obs);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        p_digit1 = 4'h1; p_digit2 = 4'h2; p_digit3 = 4'h3; p_digit4 = 4'h4;
        blink_mask = 4'b0000;
        step();
        total++;
        if (obs() !== {2'b00, 16'h1234, 4'b0000}) begin
            bad++;
            $display("FAIL passthrough_1234 got=%h exp=%h", obs(), {2'b00, 16'h1234, 4'b0000});
        end
        for (int i = 0; i < 12; i++) begin
            rand_primary();
            step();
            total++;
            if (obs() !== e_obs) begin
                bad++;
                $display("FAIL passthrough cyc=%0d got=%h exp=%h", i, obs(), e_obs);
            end
        end
    endtask

    task automatic test_message_grant();
        int acks;
        int busys;
        acks  = 0;
        busys = 0;
        blink_mask = 4'b0000;
        msg_req = 1'b1;
        m_digit1 = 4'hE; m_digit2 = 4'hE; m_digit3 = 4'h0; m_digit4 = 4'h1;
        step();
        msg_req = 1'b0;
        m_digit1 = 4'h5; m_digit2 = 4'h5; m_digit3 = 4'h5; m_digit4 = 4'h5;
        total++;
        if ({digit1, digit2, digit3, digit4, blank} !== {16'hEE01, 4'b0000}) begin
            bad++;
            $display("FAIL grant_digits got=%h exp=%h", {digit1, digit2, digit3, digit4, blank}, {16'hEE01, 4'b0000});
        end
        acks  += int'(msg_ack);
        busys += int'(busy);
        total++;
        if (obs() !== e_obs) begin
            bad++;
            $display("FAIL grant cyc=0 got=%h exp=%h", obs(), e_obs);
        end
        for (int i = 1; i < 10; i++) begin
            rand_primary();
            step();
            acks  += int'(msg_ack);
            busys += int'(busy);
            total++;
            if (obs() !== e_obs) begin
                bad++;
                $display("FAIL grant cyc=%0d got=%h exp=%h", i, obs(), e_obs);
            end
        end
        total++;
        if (acks != 1) begin
            bad++;
            $display("FAIL grant_ack_count got=%0d exp=1", acks);
        end
        total++;
        if (busys != H + G) begin
            bad++;
            $display("FAIL grant_busy_cycles got=%0d exp=%0d", busys, H + G);
        end
    endtask

    task automatic test_held_request();
        int ack_cyc[$];
        int exp_cyc[$];
        msg_req = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i == 10) msg_req = 1'b0;
            m_digit1 = 4'($urandom_range(0, 15));
            m_digit2 = 4'($urandom_range(0, 15));
            m_digit3 = 4'($urandom_range(0, 15));
            m_digit4 = 4'($urandom_range(0, 15));
            step();
            if (msg_ack === 1'b1) ack_cyc.push_back(i);
            if (e_obs[21]) exp_cyc.push_back(i);
            total++;
            if (obs() !== e_obs) begin
                bad++;
                $display("FAIL held cyc=%0d got=%h exp=%h", i, obs(), e_obs);
            end
        end
        total++;
        if (ack_cyc.size() != 2 || exp_cyc.size() != 2) begin
            bad++;
            $display("FAIL held_ack_count got=%0d exp=2", ack_cyc.size());
        end else begin
            total++;
            if (ack_cyc[0] != 0 || ack_cyc[1] - ack_cyc[0] != H + G + 1) begin
                bad++;
                $display("FAIL held_ack_spacing got=%0d,%0d exp=0,%0d", ack_cyc[0], ack_cyc[1], H + G + 1);
            end
        end
    endtask

    task automatic test_blink();
        blink_mask = 4'b1001;
        msg_req = 1'b0;
        for (int i = 0; i < 26; i++) begin
            msg_req = (i == 14);
            step();
            total++;
            if (obs() !== e_obs) begin
                bad++;
                $display("FAIL blink cyc=%0d got=%h exp=%h", i, obs(), e_obs);
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 3) blink_mask = 4'($urandom_range(0, 15));
            step();
            total++;
            if (obs() !== e_obs) begin
                bad++;
                $display("FAIL blink_maskchg cyc=%0d got=%h exp=%h", i, obs(), e_obs);
            end
        end
    endtask

    task automatic test_reset_mid_show();
        int acks;
        acks = 0;
        blink_mask = 4'b0110;
        msg_req = 1'b1;
        m_digit1 = 4'hA; m_digit2 = 4'hB; m_digit3 = 4'hC; m_digit4 = 4'hD;
        step();
        msg_req = 1'b0;
        step();
        #3 rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (obs() !== e_obs) begin
            bad++;
            $display("FAIL midshow_reset got=%h exp=%h", obs(), e_obs);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_primary();
            step();
            acks += int'(msg_ack);
            total++;
            if (obs() !== e_obs) begin
                bad++;
                $display("FAIL midshow_after cyc=%0d got=%h exp=%h", i, obs(), e_obs);
            end
        end
        total++;
        if (acks != 0) begin
            bad++;
            $display("FAIL midshow_no_ack got=%0d exp=0", acks);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_primary();
            msg_req = ($urandom_range(0, 3) == 0);
            m_digit1 = 4'($urandom_range(0, 15));
            m_digit2 = 4'($urandom_range(0, 15));
            m_digit3 = 4'($urandom_range(0, 15));
            m_digit4 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) blink_mask = 4'($urandom_range(0, 15));
            step();
            total++;
            if (obs() !== e_obs) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs(), e_obs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_message_grant();
        test_held_request();
        test_blink();
        test_reset_mid_show();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
